// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports and the allocate handshake.
// The master side is decode/issue plus writeback; the slave side is the register file.
interface regfile_mp_if #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int NUM_RD = 3,
   parameter int NUM_WR = 2
);
   logic [NUM_RD*ADDR_W-1:0] num_read_in;
   logic [NUM_RD*DATA_W-1:0] data_read_out;
   logic [NUM_RD-1:0]        ready_read_out;
   logic [NUM_WR-1:0]        write_in;
   logic [NUM_WR*ADDR_W-1:0] num_write_in;
   logic [NUM_WR*DATA_W-1:0] data_write_in;
   logic                     alloc_valid_in;
   logic [ADDR_W-1:0]        alloc_num_in;
   logic                     alloc_ready_out;
   logic [DEPTH-1:0]         pending_out;

   modport master (
      output num_read_in, write_in, num_write_in, data_write_in, alloc_valid_in, alloc_num_in,
      input  data_read_out, ready_read_out, alloc_ready_out, pending_out
   );

   modport slave (
      input  num_read_in, write_in, num_write_in, data_write_in, alloc_valid_in, alloc_num_in,
      output data_read_out, ready_read_out, alloc_ready_out, pending_out
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with pending scoreboard, allocate handshake and
// write-to-read bypass; the highest-numbered write port wins on conflicts.
module regfile_mp #(
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 8,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int NUM_RD   = 3,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 0
) (
   input logic          clk,
   input logic          rst,
   regfile_mp_if.slave  bus
);
   logic [DATA_W-1:0] mem_reg [DEPTH];
   logic [DEPTH-1:0]  pending_reg;
   logic [DEPTH-1:0]  pending_next;
   logic [DEPTH-1:0]  wr_hit;
   logic [DATA_W-1:0] wr_data [DEPTH];
   logic [DEPTH-1:0]  alloc_mask;
   logic              alloc_fire;

   // Per-register winning write; later ports overwrite earlier ones in the loop.
   always_comb begin
      wr_hit = '0;
      for (int r = 0; r < DEPTH; r++) begin
         wr_data[r] = '0;
      end
      for (int p = 0; p < NUM_WR; p++) begin
         if (bus.write_in[p]) begin
            wr_hit[bus.num_write_in[p*ADDR_W +: ADDR_W]]  = 1'b1;
            wr_data[bus.num_write_in[p*ADDR_W +: ADDR_W]] = bus.data_write_in[p*DATA_W +: DATA_W];
         end
      end
      if (ZERO_REG != 0) begin
         wr_hit[0] = 1'b0;
      end
   end

   // Ready never looks at alloc_valid_in, so the handshake has no valid->ready path.
   assign bus.alloc_ready_out = ~pending_reg[bus.alloc_num_in] | wr_hit[bus.alloc_num_in];
   assign alloc_fire          = bus.alloc_valid_in & bus.alloc_ready_out;
   assign bus.pending_out     = pending_reg;

   always_comb begin
      alloc_mask = '0;
      alloc_mask[bus.alloc_num_in] = alloc_fire;
      // Set after clear so an allocate beats a same-cycle write to the same register.
      pending_next = (pending_reg & ~wr_hit) | alloc_mask;
      if (ZERO_REG != 0) begin
         pending_next[0] = 1'b0;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] rd_idx;
         assign rd_idx = bus.num_read_in[gi*ADDR_W +: ADDR_W];
         assign bus.data_read_out[gi*DATA_W +: DATA_W] = wr_hit[rd_idx] ? wr_data[rd_idx] : mem_reg[rd_idx];
         assign bus.ready_read_out[gi] = ~pending_reg[rd_idx] | wr_hit[rd_idx];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            mem_reg[r] <= '0;
         end
         pending_reg <= '0;
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            if (wr_hit[r]) begin
               mem_reg[r] <= wr_data[r];
            end
         end
         pending_reg <= pending_next;
      end
   end
endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp; a ZERO_REG=0 and a ZERO_REG=1
// instance share stimulus and are checked against an array-based reference model.
module tb_regfile_mp;
   localparam int DW = 16;
   localparam int DP = 8;
   localparam int AW = 3;
   localparam int NR = 3;
   localparam int NW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus0 ();
   regfile_mp_if #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus1 ();

   assign bus1.num_read_in    = bus0.num_read_in;
   assign bus1.write_in       = bus0.write_in;
   assign bus1.num_write_in   = bus0.num_write_in;
   assign bus1.data_write_in  = bus0.data_write_in;
   assign bus1.alloc_valid_in = bus0.alloc_valid_in;
   assign bus1.alloc_num_in   = bus0.alloc_num_in;

   regfile_mp #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(0))
      dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   regfile_mp #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1))
      dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: index 0 = plain instance, index 1 = zero-register instance.
   logic [DW-1:0] m_mem  [2][DP];
   logic          m_pend [2][DP];
   logic          m_hit  [2][DP];
   logic [DW-1:0] m_wdat [2][DP];
   logic          m_acc  [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < DP; r++) begin
            m_mem[k][r]  = '0;
            m_pend[k][r] = 1'b0;
         end
   endtask

   task automatic set_rd(input int i, input int a);
      bus0.num_read_in[i*AW +: AW] = AW'(a);
   endtask

   task automatic set_wr(input int p, input logic en, input int a, input logic [DW-1:0] d);
      bus0.write_in[p]               = en;
      bus0.num_write_in[p*AW +: AW]  = AW'(a);
      bus0.data_write_in[p*DW +: DW] = d;
   endtask

   task automatic idle();
      bus0.write_in       = '0;
      bus0.alloc_valid_in = 1'b0;
   endtask

   // Wait off-edge, predict every output from the model and compare.
   task automatic settle();
      logic [NR*DW-1:0] o_data;
      logic [NR-1:0]    o_rdy;
      logic             o_ar;
      logic [DP-1:0]    o_pend;
      logic [DP-1:0]    e_pend;
      int               a;
      logic             e_ar;
      logic [DW-1:0]    e_d;
      #1;
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < DP; r++) begin
            m_hit[k][r]  = 1'b0;
            m_wdat[k][r] = '0;
         end
         for (int p = 0; p < NW; p++)
            if (bus0.write_in[p]) begin
               a = int'(bus0.num_write_in[p*AW +: AW]);
               m_hit[k][a]  = 1'b1;
               m_wdat[k][a] = bus0.data_write_in[p*DW +: DW];
            end
         if (k == 1) m_hit[k][0] = 1'b0;
         o_data = (k == 0) ? bus0.data_read_out   : bus1.data_read_out;
         o_rdy  = (k == 0) ? bus0.ready_read_out  : bus1.ready_read_out;
         o_ar   = (k == 0) ? bus0.alloc_ready_out : bus1.alloc_ready_out;
         o_pend = (k == 0) ? bus0.pending_out     : bus1.pending_out;
         for (int i = 0; i < NR; i++) begin
            a   = int'(bus0.num_read_in[i*AW +: AW]);
            e_d = (k == 1 && a == 0) ? '0 : (m_hit[k][a] ? m_wdat[k][a] : m_mem[k][a]);
            chk($sformatf("u%0d_rd%0d_data", k, i), 32'(o_data[i*DW +: DW]), 32'(e_d));
            chk($sformatf("u%0d_rd%0d_ready", k, i), 32'(o_rdy[i]), 32'(!m_pend[k][a] || m_hit[k][a]));
         end
         a    = int'(bus0.alloc_num_in);
         e_ar = !m_pend[k][a] || m_hit[k][a];
         chk($sformatf("u%0d_alloc_ready", k), 32'(o_ar), 32'(e_ar));
         for (int r = 0; r < DP; r++) e_pend[r] = m_pend[k][r];
         chk($sformatf("u%0d_pending", k), 32'(o_pend), 32'(e_pend));
         m_acc[k] = bus0.alloc_valid_in && e_ar && !(k == 1 && a == 0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < DP; r++)
            if (m_hit[k][r]) begin
               m_mem[k][r]  = m_wdat[k][r];
               m_pend[k][r] = 1'b0;
            end
         if (m_acc[k]) m_pend[k][int'(bus0.alloc_num_in)] = 1'b1;
      end
      #1;
   endtask

   // Assert reset between edges, check, then release; the next edge runs normally.
   task automatic mid_reset();
      #1;
      rst = 1'b1;
      model_reset();
      settle();
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   initial begin
      bus0.num_read_in   = '0;
      bus0.num_write_in  = '0;
      bus0.data_write_in = '0;
      bus0.alloc_num_in  = '0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Reset: preload r3 then assert reset between edges
      set_wr(0, 1'b1, 3, 16'h1234);
      settle(); tick();
      idle();
      set_rd(0, 3);
      #2;
      chk("pre_reset_r3", 32'(bus0.data_read_out[0 +: DW]), 32'h1234);
      rst = 1'b1;
      #1;
      chk("reset_r3", 32'(bus0.data_read_out[0 +: DW]), 32'h0);
      chk("reset_pending", 32'(bus0.pending_out), 32'h0);
      chk("reset_ready", 32'(bus0.ready_read_out), 32'h7);
      chk("reset_alloc_ready", 32'(bus0.alloc_ready_out), 32'h1);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Write with same-cycle bypass
      set_wr(0, 1'b1, 5, 16'hBEEF);
      set_rd(2, 5);
      settle();
      chk("bypass_data", 32'(bus0.data_read_out[2*DW +: DW]), 32'hBEEF);
      chk("bypass_ready", 32'(bus0.ready_read_out[2]), 32'h1);
      tick();
      idle();
      settle();
      chk("stored_r5", 32'(bus0.data_read_out[2*DW +: DW]), 32'hBEEF);
      tick();

      // Write conflict: port 1 wins
      set_wr(0, 1'b1, 2, 16'h1111);
      set_wr(1, 1'b1, 2, 16'h2222);
      set_rd(1, 2);
      settle();
      chk("conflict_bypass", 32'(bus0.data_read_out[DW +: DW]), 32'h2222);
      tick();
      idle();
      settle();
      chk("conflict_stored", 32'(bus0.data_read_out[DW +: DW]), 32'h2222);
      tick();

      // Scoreboard round trip on r4
      bus0.alloc_valid_in = 1'b1;
      bus0.alloc_num_in   = 3'd4;
      set_rd(0, 4);
      settle();
      chk("alloc4_ready", 32'(bus0.alloc_ready_out), 32'h1);
      tick();
      settle();
      chk("r4_pending", 32'(bus0.pending_out[4]), 32'h1);
      chk("r4_read_not_ready", 32'(bus0.ready_read_out[0]), 32'h0);
      chk("realloc4_blocked", 32'(bus0.alloc_ready_out), 32'h0);
      tick();
      idle();
      set_wr(0, 1'b1, 4, 16'h00AA);
      settle();
      chk("r4_wb_ready", 32'(bus0.ready_read_out[0]), 32'h1);
      chk("r4_wb_data", 32'(bus0.data_read_out[0 +: DW]), 32'h00AA);
      tick();
      idle();
      settle();
      chk("r4_released", 32'(bus0.pending_out[4]), 32'h0);
      tick();

      // Allocate and write r6 in the same cycle while it is pending
      bus0.alloc_valid_in = 1'b1;
      bus0.alloc_num_in   = 3'd6;
      settle(); tick();
      set_wr(1, 1'b1, 6, 16'h0F0F);
      settle();
      chk("r6_alloc_with_write", 32'(bus0.alloc_ready_out), 32'h1);
      tick();
      idle();
      set_rd(1, 6);
      settle();
      chk("r6_data", 32'(bus0.data_read_out[DW +: DW]), 32'h0F0F);
      chk("r6_still_pending", 32'(bus0.pending_out[6]), 32'h1);
      tick();

      // Register 0 on the zero-register instance
      set_wr(1, 1'b1, 0, 16'hFFFF);
      bus0.alloc_valid_in = 1'b1;
      bus0.alloc_num_in   = 3'd0;
      set_rd(0, 0);
      settle();
      chk("z_r0_bypass", 32'(bus1.data_read_out[0 +: DW]), 32'h0);
      chk("z_alloc_ready", 32'(bus1.alloc_ready_out), 32'h1);
      tick();
      idle();
      settle();
      chk("z_r0_data", 32'(bus1.data_read_out[0 +: DW]), 32'h0);
      chk("z_r0_pending", 32'(bus1.pending_out[0]), 32'h0);
      chk("z_r0_alloc_ready", 32'(bus1.alloc_ready_out), 32'h1);
      chk("nz_r0_data", 32'(bus0.data_read_out[0 +: DW]), 32'hFFFF);
      tick();

      // Randomised traffic with collisions, allocates and occasional mid-cycle resets
      for (int n = 0; n < 600; n++) begin
         for (int p = 0; p < NW; p++)
            set_wr(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, DP-1)), DW'($urandom));
         if ($urandom_range(0, 3) == 0)
            bus0.num_write_in[AW +: AW] = bus0.num_write_in[0 +: AW];
         for (int i = 0; i < NR; i++)
            set_rd(i, ($urandom_range(0, 3) == 0) ? int'(bus0.num_write_in[0 +: AW])
                                                  : int'($urandom_range(0, DP-1)));
         bus0.alloc_valid_in = 1'($urandom_range(0, 1));
         bus0.alloc_num_in   = AW'($urandom_range(0, DP-1));
         if ($urandom_range(0, 79) == 0) begin
            mid_reset();
         end else begin
            settle();
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file that succeeds the fixed 8×16, 2-write/3-read register file. It adds a per-register pending scoreboard with an allocate handshake, write-to-read bypass, deterministic write-port priority and asynchronous reset. It sits between decode/issue (read ports, allocate) and the execution writeback buses (write ports).

## Interface

Parameters:
- DATA_W, 16, register width in bits
- DEPTH, 8, number of registers (power of two, ≥2)
- ADDR_W, $clog2(DEPTH), register index width
- NUM_RD, 3, number of read ports
- NUM_WR, 2, number of write ports
- ZERO_REG, 0, when 1 register 0 reads as 0, ignores writes and is never pending

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- num_read_in  in  NUM_RD*ADDR_W  read indices, port i at [i*ADDR_W +: ADDR_W]
- data_read_out  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- ready_read_out  out  NUM_RD  1 = register i's value is valid (not pending, or being written this cycle)
- write_in  in  NUM_WR  per-port write enable
- num_write_in  in  NUM_WR*ADDR_W  write indices
- data_write_in  in  NUM_WR*DATA_W  write data
- alloc_valid_in  in  1  request to mark alloc_num_in pending
- alloc_num_in  in  ADDR_W  register to allocate
- alloc_ready_out  out  1  allocate accepted this cycle
- pending_out  out  DEPTH  current scoreboard, bit r = register r pending

## Operation

- Storage: DEPTH×DATA_W array plus DEPTH-bit pending vector.
- Reset (rst high, asynchronous): all registers cleared to 0, pending cleared to 0; therefore data_read_out = 0, ready_read_out = all 1, pending_out = 0, alloc_ready_out = ~pending[alloc_num_in] = 1.
- Write: for every port p with write_in[p], register num_write_in[p] takes data_write_in[p] at the next edge. The write also clears that register's pending bit.
- Write conflict: if two or more enabled ports target the same register, the highest-numbered port wins. Every enabled port still clears pending.
- Read, combinational: data_read_out[i] returns the winning same-cycle write data if any enabled write port targets num_read_in[i] (bypass, same priority rule); otherwise it returns the stored value.
- ready_read_out[i] = ~pending[num_read_in[i]] | (any enabled write targets num_read_in[i]).
- Allocate handshake: alloc_ready_out = alloc_valid_in-independent; high when the target is not pending, or when the target is being written this cycle.
  - Transfer occurs when alloc_valid_in & alloc_ready_out; the target's pending bit is set at the edge.
  - Requesters hold valid/num until ready.
  - On a transfer, a same-cycle write to the same register still updates the data; set overrides clear, so pending ends at 1.
- ZERO_REG=1: register 0 reads 0, is unaffected by writes, has pending forced to 0, and any allocate to 0 is accepted but has no effect.
- Out-of-range indices cannot occur (DEPTH is a power of two).

## Timing

- Read latency 0 (combinational from num_read_in, write_in, num_write_in, data_write_in and state).
- Write visible in storage 1 cycle after the edge; visible via bypass in the same cycle.
- pending_out and ready_read_out reflect an allocate from the cycle after transfer.
- alloc_ready_out is combinational; no combinational path from alloc_valid_in to alloc_ready_out.
- rst asserted mid-operation aborts all in-flight writes and allocates that edge; on deassertion, the first edge behaves normally.

## Test plan

- Reset: pre-load r3=0x1234, assert rst asynchronously between edges -> data_read_out immediately 0 for r3, pending_out=0, ready_read_out all 1.
- Write/bypass: write port 0 r5=0xBEEF, read port 2 r5 same cycle -> data 0xBEEF, ready 1; next cycle stored value reads 0xBEEF with write_in=0.
- Write conflict: ports 0 and 1 both write r2 (0x1111, 0x2222) -> read r2 = 0x2222 in the same cycle and afterwards.
- Scoreboard: allocate r4 -> next cycle pending_out[4]=1, read r4 ready 0, allocate r4 again gives alloc_ready_out=0; write r4=0x00AA -> same cycle ready 1 and data 0x00AA, next cycle pending_out[4]=0.
- Allocate+write same register same cycle: r6 pending, write r6=0x0F0F while allocating r6 -> alloc accepted, r6=0x0F0F stored, pending_out[6] stays 1.
- ZERO_REG=1: write r0=0xFFFF and allocate r0 -> r0 reads 0, pending_out[0]=0, alloc_ready_out=1.
